pipe_skid_reg: RTL and testbench

- Elastic pipeline register between two datapath stages, using a valid/ready handshake on both sides.
- Holds up to two words: one main register and one skid register. Upstream ready is therefore fully registered, so backpressure never forms a combinational path from out_ready to in_ready.
- It is the consuming end of a stage register: it accepts words from the producing stage and presents them downstream without loss or duplication.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_stall_counter.sv | 40 ++++
 rtl/pipe_skid_reg.sv | 138 +++++++++++++
 tb/tb_pipe_skid_reg.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline register slice.
//   - pipe_state_e : occupancy state encoding (EMPTY / ONE / FULL)
//   - PIPE_WIDTH_DEFAULT, PIPE_STALL_CNT_W_DEFAULT : default parameter values
//   - pipe_cap_left : number of free word slots for a given state
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int PIPE_WIDTH_DEFAULT       = 32;
  localparam int PIPE_STALL_CNT_W_DEFAULT = 16;

  // Occupancy of the main/skid register pair. 2'd3 is never entered.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // Free slots remaining in a given state; an illegal encoding reports none.
  function automatic logic [1:0] pipe_cap_left(input pipe_state_e st);
    logic [1:0] cap;
    case (st)
      ST_EMPTY: cap = 2'd2;
      ST_ONE:   cap = 2'd1;
      ST_FULL:  cap = 2'd0;
      default:  cap = 2'd0;
    endcase
    return cap;
  endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// ---------------------------------------------------------------------------
// pipe_stall_counter
// Saturating event counter: counts clock edges on which inc is high and
// sticks at all-ones instead of wrapping.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (count returns to 0)
//   inc   - count this edge
//   cnt   - current count, W bits, registered
// ---------------------------------------------------------------------------
module pipe_stall_counter
  import pipe_pkg::*;
#(
  parameter int W = PIPE_STALL_CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;
  logic         at_max_s;

  assign at_max_s = (cnt_r == {W{1'b1}});

  // Count enabled edges, holding at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (inc && !at_max_s) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
// Elastic two-entry pipeline register (main + skid) with valid/ready on both
// sides. in_ready comes straight from a flop, so out_ready never reaches
// in_ready combinationally; the skid register catches the word that was
// already in flight when downstream stalled.
//
// Optional feature (macro PIPE_SKID_STALL_CNT_EN): adds the stall_cnt output,
// a saturating count of edges with out_valid=1 and out_ready=0.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset; discards all held words
//   in_data   - word from upstream (WIDTH bits)
//   in_valid  - upstream word present
//   in_ready  - block can accept a word this cycle (registered)
//   out_data  - word to downstream, always the main register
//   out_valid - out_data valid (registered)
//   out_ready - downstream accepts this cycle
//   stall_cnt - stall cycle count (only with PIPE_SKID_STALL_CNT_EN)
// ---------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH       = PIPE_WIDTH_DEFAULT,
  parameter int STALL_CNT_W = PIPE_STALL_CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  // Reject degenerate configurations at elaboration time.
  if (WIDTH < 1 || STALL_CNT_W < 2) begin : g_param_check
    $error("pipe_skid_reg: WIDTH must be >= 1 and STALL_CNT_W >= 2");
  end

  pipe_state_e      state_r;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             in_xfer_s;
  logic             out_xfer_s;

  assign in_xfer_s  = in_valid & in_ready_r;
  assign out_xfer_s = out_valid_r & out_ready;

  // Occupancy FSM with data registers and registered handshake outputs.
  // Data registers only load on an actual transfer, so X on an idle
  // in_data can never reach out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      main_r      <= '0;
      skid_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            main_r      <= in_data;
            state_r     <= ST_ONE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b1;
          end else begin
            state_r     <= ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            // Pass-through: new word replaces the one leaving.
            main_r      <= in_data;
            state_r     <= ST_ONE;
          end else if (in_xfer_s) begin
            // Downstream stalled while a word arrived: park it in skid.
            skid_r      <= in_data;
            state_r     <= ST_FULL;
            in_ready_r  <= 1'b0;
          end else if (out_xfer_s) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
          end else begin
            state_r     <= ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain case exists.
          if (out_xfer_s) begin
            main_r      <= skid_r;
            state_r     <= ST_ONE;
            in_ready_r  <= 1'b1;
          end else begin
            state_r     <= ST_FULL;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty slice.
          state_r     <= ST_EMPTY;
          main_r      <= '0;
          skid_r      <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;

`ifdef PIPE_SKID_STALL_CNT_EN
  logic stall_s;

  assign stall_s = out_valid_r & ~out_ready;

  pipe_stall_counter #(
    .W (STALL_CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_s),
    .cnt   (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
// Scoreboard bench: the reference model is an ordered queue of the words the
// slice should hold (capacity two). Accepted words are pushed at the clock
// edge; a monitor on the falling edge checks the handshake flags against the
// queue occupancy, checks out_data against the queue head and pops on an
// output transfer.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam int W = 32;
`ifdef PIPE_SKID_STALL_CNT_EN
  localparam int SCW = 4;
`else
  localparam int SCW = 16;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [SCW-1:0] stall_cnt;
  int             stall_mdl = 0;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb_q[$];        // words expected to be inside the slice
  bit           mdl_ready = 1'b1;
  bit           last_acc  = 1'b0;

  pipe_skid_reg #(
    .WIDTH       (W),
    .STALL_CNT_W (SCW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard push: a word is accepted when offered while the model has room.
  always @(posedge clk) begin
    last_acc = 1'b0;
    if (rst_n && in_valid && mdl_ready) begin
      sb_q.push_back(in_data);
      last_acc = 1'b1;
    end
  end

  // Monitor: compare flags and head word mid-cycle, then retire on pop.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (sb_q.size() < 2)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (sb_q.size() > 0)});
      if (sb_q.size() > 0 && out_valid) chk("out_data", out_data, sb_q[0]);
`ifdef PIPE_SKID_STALL_CNT_EN
      chk("stall_cnt", W'(stall_cnt), W'(stall_mdl));
      if (sb_q.size() > 0 && !out_ready && stall_mdl < 15) stall_mdl++;
`endif
      mdl_ready = (sb_q.size() < 2);
      if (sb_q.size() > 0 && out_ready) void'(sb_q.pop_front());
    end else begin
      mdl_ready = 1'b1;
    end
  end

  // Drive one cycle of inputs, then advance to just after the next edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  // Hold a word with out_ready high until the slice takes it (bounded).
  task automatic send_until_acc(input logic [W-1:0] d);
    int n;
    n = 0;
    do begin
      step(1'b1, d, 1'b1);
      n++;
    end while (!last_acc && n < 50);
    chk("send_timeout", {31'd0, last_acc}, 32'd1);
  endtask

  initial begin
    // Reset with a word offered: nothing may be captured.
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
`ifdef PIPE_SKID_STALL_CNT_EN
    chk("rst_stall_cnt", W'(stall_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    step(1'b1, 32'hDEADBEEF, 1'b0);
    chk("first_load_acc", {31'd0, last_acc}, 32'd1);
    chk("first_out_valid", {31'd0, out_valid}, 32'd1);
    chk("first_out_data", out_data, 32'hDEADBEEF);
    drain(3);

    // Streaming 1..100, one word accepted every cycle.
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, W'(i), 1'b1);
      chk("stream_acc", {31'd0, last_acc}, 32'd1);
    end
    drain(3);

    // Backpressure: 5 and 6 fill the slice, 7 must be held off.
    step(1'b1, 32'd5, 1'b0);
    step(1'b1, 32'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'd7, 1'b0);
      chk("bp_hold_off", {31'd0, last_acc}, 32'd0);
    end
    send_until_acc(32'd7);
    drain(4);

    // Push and pop on the same edge while holding one word.
    step(1'b1, 32'd9, 1'b0);
    step(1'b1, 32'd10, 1'b1);
    chk("simul_acc", {31'd0, last_acc}, 32'd1);
    chk("simul_data", out_data, 32'd10);
    drain(3);

    // Asynchronous reset between edges while full of 11 and 12.
    step(1'b1, 32'd11, 1'b0);
    step(1'b1, 32'd12, 1'b0);
    step(1'b0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
`ifdef PIPE_SKID_STALL_CNT_EN
    stall_mdl = 0;
`endif
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    drain(4);

`ifdef PIPE_SKID_STALL_CNT_EN
    // Saturation: hold one word stalled for 20 cycles.
    step(1'b1, 32'd42, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0);
    chk("stall_sat", W'(stall_cnt), 32'd15);
    rst_n = 1'b0;
    sb_q.delete();
    stall_mdl = 0;
    #1;
    chk("stall_rst", W'(stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`endif

    // Random traffic; upstream keeps an unaccepted word stable.
    for (int i = 0; i < 3000; i++) begin
      logic         v;
      logic [W-1:0] d;
      if (in_valid && !last_acc) begin
        v = 1'b1;
        d = in_data;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = $urandom;
      end
      step(v, d, ($urandom_range(0, 2) != 0));
    end
    drain(4);
    chk("final_empty", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
